// File: rtl/alu_mem_port_pkg.sv
// Shared definitions for the serial ALU memory port.
//   state_e   : controller states
//   alu_op_e  : ALU operation codes used by the surrounding datapath
//   shift_len : number of serial SHIFT cycles for a transfer
package alu_mem_port_pkg;

  localparam int DEF_REG_BITS = 8;
  localparam int DEF_NSHIFT   = 2;

  typedef enum logic [2:0] {
    OP_ADD,
    OP_SUB,
    OP_AND,
    OP_OR,
    OP_XOR,
    OP_SHL
  } alu_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_REQ,
    ST_LOAD_WAIT,
    ST_SHIFT,
    ST_STORE_REQ
  } state_e;

  // Serial cycles per transfer: a pair moves twice the register width.
  function automatic int shift_len(logic pair, int reg_bits, int nshift);
    return pair ? (2 * reg_bits) / nshift : reg_bits / nshift;
  endfunction

endpackage

// File: rtl/alu_mem_port_if.sv
// Memory request/response bus plus the serial ALU link.
//   master : the alu_mem_port side (issues requests, feeds the ALU)
//   slave  : the memory / ALU side
interface alu_mem_port_if #(
  parameter int REG_BITS = 8,
  parameter int NSHIFT   = 2
);
  logic                  mem_req_valid;
  logic                  mem_req_write;
  logic [2*REG_BITS-1:0] mem_req_wdata;
  logic                  mem_req_ready;
  logic                  mem_rsp_valid;
  logic [2*REG_BITS-1:0] mem_rsp_data;
  logic                  alu_advance;
  logic [NSHIFT-1:0]     alu_data_in;
  logic [NSHIFT-1:0]     alu_data_out;
  logic                  alu_op_done;

  modport master (
    output mem_req_valid, mem_req_write, mem_req_wdata, alu_advance, alu_data_in,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data, alu_data_out, alu_op_done
  );

  modport slave (
    input  mem_req_valid, mem_req_write, mem_req_wdata, alu_advance, alu_data_in,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data, alu_data_out, alu_op_done
  );
endinterface

// File: rtl/alu_mem_port_shifter.sv
// Operand shift register and result capture for the serial ALU link.
//   i_clear     : zero operand and result (transaction start)
//   i_load      : load operand from memory response data
//   i_shift     : SHIFT cycle; emit low chunk, shift right, capture ALU chunk
//   i_cnt       : SHIFT cycle index selecting the result chunk
//   i_alu_out   : serial result chunk from the ALU
//   o_data_in   : serial operand chunk to the ALU (zero outside SHIFT)
//   o_result    : captured result
module alu_mem_port_shifter #(
  parameter int REG_BITS = 8,
  parameter int NSHIFT   = 2,
  parameter int CNT_W    = 3
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_clear,
  input  logic                  i_load,
  input  logic [2*REG_BITS-1:0] i_load_data,
  input  logic                  i_shift,
  input  logic [CNT_W-1:0]      i_cnt,
  input  logic [NSHIFT-1:0]     i_alu_out,
  output logic [NSHIFT-1:0]     o_data_in,
  output logic [2*REG_BITS-1:0] o_result
);
  localparam int W      = 2 * REG_BITS;
  localparam int NCHUNK = W / NSHIFT;

  logic [W-1:0] r_op;
  logic [W-1:0] r_res;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_op  <= '0;
      r_res <= '0;
    end else if (i_clear) begin
      r_op  <= '0;
      r_res <= '0;
    end else if (i_load) begin
      r_op <= i_load_data;
    end else if (i_shift) begin
      r_op <= r_op >> NSHIFT;
      // Decoded chunk write keeps the part-select index constant.
      for (int k = 0; k < NCHUNK; k++) begin
        if (i_cnt == CNT_W'(k)) r_res[k*NSHIFT +: NSHIFT] <= i_alu_out;
      end
    end
  end

  assign o_data_in = i_shift ? r_op[NSHIFT-1:0] : '0;
  assign o_result  = r_res;

endmodule

// File: rtl/alu_mem_port.sv
// Sequences an optional memory load, a serial ALU pass and an optional
// memory store.
//   i_clk, i_rst    : clock, asynchronous active-high reset
//   i_start         : begin transaction (sampled in IDLE only)
//   i_pair          : 1 = 2*REG_BITS transfer, 0 = REG_BITS transfer
//   i_need_load     : fetch operand from memory first
//   i_need_store    : write result to memory afterwards
//   bus             : memory request/response and serial ALU link
//   o_busy          : not IDLE
//   o_done          : one-cycle completion pulse
//   o_result        : captured result, stable from done until next start
//   o_sync_error    : sticky ALU last-cycle disagreement
module alu_mem_port
  import alu_mem_port_pkg::*;
#(
  parameter int REG_BITS = DEF_REG_BITS,
  parameter int NSHIFT   = DEF_NSHIFT
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic                  i_pair,
  input  logic                  i_need_load,
  input  logic                  i_need_store,
  alu_mem_port_if.master        bus,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [2*REG_BITS-1:0] o_result,
  output logic                  o_sync_error
);
  localparam int W      = 2 * REG_BITS;
  localparam int NCHUNK = W / NSHIFT;
  localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  if ((REG_BITS % NSHIFT) != 0) begin : g_bad_cfg
    $error("REG_BITS must be a multiple of NSHIFT");
  end

  state_e           r_state, w_next;
  logic             r_pair, r_need_store;
  logic [CNT_W-1:0] r_cnt;
  logic             r_done, r_sync_err;

  logic             w_clear, w_load, w_shift, w_last, w_done_set;
  logic [CNT_W-1:0] w_last_idx;
  logic [W-1:0]     w_result;

  assign w_shift    = (r_state == ST_SHIFT);
  assign w_last_idx = CNT_W'(shift_len(r_pair, REG_BITS, NSHIFT) - 1);
  assign w_last     = (r_cnt == w_last_idx);

  always_comb begin
    w_next     = r_state;
    w_clear    = 1'b0;
    w_load     = 1'b0;
    w_done_set = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_clear = 1'b1;
          w_next  = i_need_load ? ST_LOAD_REQ : ST_SHIFT;
        end
      end
      ST_LOAD_REQ: begin
        if (bus.mem_req_ready) w_next = ST_LOAD_WAIT;
      end
      ST_LOAD_WAIT: begin
        if (bus.mem_rsp_valid) begin
          w_load = 1'b1;
          w_next = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (w_last) begin
          w_next     = r_need_store ? ST_STORE_REQ : ST_IDLE;
          w_done_set = ~r_need_store;
        end
      end
      ST_STORE_REQ: begin
        if (bus.mem_req_ready) begin
          w_next     = ST_IDLE;
          w_done_set = 1'b1;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_pair       <= 1'b0;
      r_need_store <= 1'b0;
      r_cnt        <= '0;
      r_done       <= 1'b0;
      r_sync_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= w_done_set;
      if (w_clear) begin
        r_pair       <= i_pair;
        r_need_store <= i_need_store;
        r_cnt        <= '0;
      end else if (w_shift) begin
        r_cnt <= w_last ? '0 : r_cnt + 1'b1;
      end
      // ALU must flag exactly the final serial cycle.
      if (w_shift && (bus.alu_op_done != w_last)) r_sync_err <= 1'b1;
    end
  end

  alu_mem_port_shifter #(
    .REG_BITS (REG_BITS),
    .NSHIFT   (NSHIFT),
    .CNT_W    (CNT_W)
  ) u_shifter (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_clear     (w_clear),
    .i_load      (w_load),
    .i_load_data (bus.mem_rsp_data),
    .i_shift     (w_shift),
    .i_cnt       (r_cnt),
    .i_alu_out   (bus.alu_data_out),
    .o_data_in   (bus.alu_data_in),
    .o_result    (w_result)
  );

  // Request outputs decode from state only, never from mem_req_ready.
  assign bus.mem_req_valid = (r_state == ST_LOAD_REQ) || (r_state == ST_STORE_REQ);
  assign bus.mem_req_write = (r_state == ST_STORE_REQ);
  assign bus.mem_req_wdata = (r_state == ST_STORE_REQ) ? w_result : '0;
  assign bus.alu_advance   = w_shift;

  assign o_busy       = (r_state != ST_IDLE);
  assign o_done       = r_done;
  assign o_result     = w_result;
  assign o_sync_error = r_sync_err;

endmodule

// File: tb/tb_alu_mem_port.sv
module tb_alu_mem_port;
  localparam int RB = 8;
  localparam int NS = 2;
  localparam int W  = 2 * RB;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, pair = 1'b0, need_load = 1'b0, need_store = 1'b0;
  logic busy, done, sync_error;
  logic [W-1:0] result;

  alu_mem_port_if #(.REG_BITS(RB), .NSHIFT(NS)) bus();

  alu_mem_port #(.REG_BITS(RB), .NSHIFT(NS)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_start      (start),
    .i_pair       (pair),
    .i_need_load  (need_load),
    .i_need_store (need_store),
    .bus          (bus.master),
    .o_busy       (busy),
    .o_done       (done),
    .o_result     (result),
    .o_sync_error (sync_error)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [W-1:0]  exp_q[$];
  logic [NS-1:0] din_log[$];
  int done_cnt = 0, st_cnt = 0;

  // ALU and memory models
  logic [NS-1:0] alu_mask = '0;
  bit            alu_seq_mode = 0, sync_mode = 0, cur_pair = 0;
  logic [NS-1:0] seq[8];
  int            adv_idx = 0;
  bit            was_adv = 0, ld_acc = 0;
  int            rsp_lat = 0, rsp_cd = -1, stray = 0;
  logic [W-1:0]  cur_rsp = '0;

  assign bus.alu_op_done  = bus.alu_advance &&
                            (sync_mode ? (adv_idx == 2) : (adv_idx == (cur_pair ? 7 : 3)));
  assign bus.alu_data_out = alu_seq_mode ? seq[adv_idx % 8] : (bus.alu_data_in ^ alu_mask);

  task automatic chk(string name, logic [W-1:0] act, logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail(string name);
    checks++;
    errors++;
    $display("FAIL %s: event seen/missing contrary to expectation", name);
  endtask

  // Scoreboard / monitor, sampled mid-cycle
  always @(negedge clk) begin
    was_adv = bus.alu_advance;
    if (bus.alu_advance) din_log.push_back(bus.alu_data_in);
    ld_acc = bus.mem_req_valid && bus.mem_req_ready && !bus.mem_req_write;
    if (bus.mem_req_valid && bus.mem_req_ready && bus.mem_req_write) begin
      st_cnt++;
      if (exp_q.size() == 0) fail("store_unexpected");
      else chk("store_wdata", bus.mem_req_wdata, exp_q[0]);
    end
    if (done) begin
      done_cnt++;
      if (exp_q.size() == 0) fail("done_unexpected");
      else chk("result", result, exp_q.pop_front());
    end
  end

  always @(posedge clk) begin
    #1;
    if (rst) begin
      adv_idx = 0;
      rsp_cd = -1;
      bus.mem_rsp_valid = 1'b0;
      bus.mem_rsp_data = '0;
    end else begin
      if (was_adv && bus.alu_advance) adv_idx++;
      else adv_idx = 0;
      bus.mem_rsp_valid = 1'b0;
      if (ld_acc) rsp_cd = rsp_lat;
      if (rsp_cd == 0) begin
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data = cur_rsp;
        rsp_cd = -1;
      end else if (rsp_cd > 0) rsp_cd--;
      if (stray > 0) begin
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data = 16'hFFFF;
        stray--;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(bit p, bit nl, bit ns, logic [W-1:0] rsp, logic [W-1:0] exp);
    cur_pair = p; cur_rsp = rsp;
    pair = p; need_load = nl; need_store = ns;
    exp_q.push_back(exp);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(int n0, string name);
    for (int i = 0; i < 200 && done_cnt == n0; i++) tick();
    if (done_cnt == n0) fail(name);
  endtask

  typedef struct {
    bit            pair, nl, ns;
    logic [W-1:0]  rsp;
    logic [NS-1:0] mask;
    logic [W-1:0]  exp_res;
    logic [7:0]    exp_din;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int d0, s0, k;
    logic [7:0] din_pk;
    #200000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, s0, k;
    logic [7:0] din_pk;
    vecs[0] = '{0, 1, 0, 16'h00B4, 2'd0, 16'h00B4, 8'hB4};
    vecs[1] = '{0, 1, 0, 16'hABCD, 2'd0, 16'h00CD, 8'hCD};
    vecs[2] = '{1, 1, 0, 16'hABCD, 2'd3, 16'h5432, 8'hCD};
    vecs[3] = '{0, 0, 0, 16'h0000, 2'd2, 16'h00AA, 8'h00};
    vecs[4] = '{1, 0, 1, 16'h0000, 2'd1, 16'h5555, 8'h00};
    vecs[5] = '{1, 1, 1, 16'h1234, 2'd0, 16'h1234, 8'h34};
    vecs[6] = '{0, 1, 1, 16'hFF0F, 2'd1, 16'h005A, 8'h0F};
    seq = '{2'd3, 2'd0, 2'd2, 2'd1, 2'd0, 2'd0, 2'd1, 2'd2};
    bus.mem_req_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", bus.mem_req_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_advance", bus.alu_advance, 0);
    rst = 1'b0;
    tick();

    // Table-driven transactions
    for (int v = 0; v < 7; v++) begin
      d0 = done_cnt; s0 = st_cnt;
      alu_mask = vecs[v].mask;
      din_log.delete();
      do_start(vecs[v].pair, vecs[v].nl, vecs[v].ns, vecs[v].rsp, vecs[v].exp_res);
      wait_done(d0, "vec_done_timeout");
      tick();
      chk("vec_done_once", W'(done_cnt - d0), 1);
      chk("vec_store_cnt", W'(st_cnt - s0), W'(vecs[v].ns));
      chk("vec_sync", sync_error, 0);
      chk("vec_busy", busy, 0);
      if (din_log.size() < 4) fail("vec_din_count");
      else begin
        din_pk = {din_log[3], din_log[2], din_log[1], din_log[0]};
        chk("vec_din", W'(din_pk), W'(vecs[v].exp_din));
      end
    end

    // Pair store with ready held low for three cycles
    alu_seq_mode = 1;
    bus.mem_req_ready = 1'b0;
    d0 = done_cnt; s0 = st_cnt;
    do_start(1, 0, 1, 16'h0000, 16'h9063);
    k = 0;
    while (!(bus.mem_req_valid && bus.mem_req_write) && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k >= 100) fail("store_req_timeout");
    chk("store_wdata_c1", bus.mem_req_wdata, 16'h9063);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("store_hold_valid", W'(bus.mem_req_valid && bus.mem_req_write), 1);
      chk("store_hold_wdata", bus.mem_req_wdata, 16'h9063);
    end
    chk("store_no_early_done", W'(done_cnt - d0), 0);
    @(posedge clk);
    #1;
    bus.mem_req_ready = 1'b1;
    wait_done(d0, "store_done_timeout");
    tick();
    chk("store_accepts", W'(st_cnt - s0), 1);
    alu_seq_mode = 0;

    // Back-to-back: start in the done cycle
    alu_mask = '0;
    d0 = done_cnt;
    do_start(0, 0, 0, 16'h0000, 16'h0000);
    k = 0;
    while (!done && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k >= 100) fail("b2b_first_timeout");
    alu_mask = 2'd3;
    cur_pair = 0; pair = 0; need_load = 0; need_store = 0;
    exp_q.push_back(16'h00FF);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("b2b_busy", busy, 1);
    chk("b2b_advance", bus.alu_advance, 1);
    wait_done(d0 + 1, "b2b_second_timeout");
    tick();
    chk("b2b_done_cnt", W'(done_cnt - d0), 2);

    // Start while in LOAD_WAIT is ignored
    alu_mask = '0;
    rsp_lat = 3;
    d0 = done_cnt;
    do_start(0, 1, 0, 16'h0077, 16'h0077);
    k = 0;
    while (!(busy && !bus.mem_req_valid && !bus.alu_advance) && k < 50) begin
      tick();
      k++;
    end
    if (k >= 50) fail("lw_reach_timeout");
    start = 1'b1; pair = 1'b1; need_load = 1'b0;
    tick();
    start = 1'b0;
    wait_done(d0, "lw_done_timeout");
    repeat (20) tick();
    chk("lw_single_done", W'(done_cnt - d0), 1);
    chk("lw_idle", busy, 0);
    rsp_lat = 0;

    // Sync error: op_done on cycle 2 of 4, sticky until reset
    sync_mode = 1;
    d0 = done_cnt;
    do_start(0, 0, 0, 16'h0000, 16'h0000);
    wait_done(d0, "sync_done_timeout");
    tick();
    chk("sync_set", sync_error, 1);
    sync_mode = 0;
    d0 = done_cnt;
    do_start(0, 0, 0, 16'h0000, 16'h0000);
    wait_done(d0, "sync2_done_timeout");
    tick();
    chk("sync_sticky", sync_error, 1);
    rst = 1'b1;
    tick();
    chk("sync_cleared", sync_error, 0);
    rst = 1'b0;
    tick();

    // Reset in the middle of an 8-cycle shift
    d0 = done_cnt;
    do_start(1, 1, 0, 16'hFFFF, 16'hFFFF);
    k = 0;
    while (!(bus.alu_advance && adv_idx == 3) && k < 50) begin
      tick();
      k++;
    end
    if (k >= 50) fail("midrst_reach_timeout");
    #2;
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("midrst_valid", bus.mem_req_valid, 0);
    chk("midrst_write", bus.mem_req_write, 0);
    chk("midrst_wdata", bus.mem_req_wdata, 0);
    chk("midrst_advance", bus.alu_advance, 0);
    chk("midrst_data_in", W'(bus.alu_data_in), 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_sync", sync_error, 0);
    chk("midrst_result", result, 0);
    tick();
    rst = 1'b0;
    stray = 1;
    repeat (4) tick();
    chk("stray_busy", busy, 0);
    chk("stray_result", result, 0);
    chk("stray_advance", bus.alu_advance, 0);
    chk("stray_no_done", W'(done_cnt - d0), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_mem_port.md
ALU_MEM_PORT -- requirements
Module: alu_mem_port

Interface
REQ-001 Parameters: REG_BITS default 8, register width; NSHIFT default 2, bits per serial cycle; REG_BITS divisible by NSHIFT.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-004 start  input  1  begin transaction; sampled only in IDLE.
REQ-005 pair  input  1  1: 2*REG_BITS-bit transfer; 0: REG_BITS-bit; latched at start.
REQ-006 need_load  input  1  fetch operand from memory before shifting; latched at start.
REQ-007 need_store  input  1  write captured result to memory after shifting; latched at start.
REQ-008 mem_req_valid  output  1  memory request pending.
REQ-009 mem_req_write  output  1  1 store, 0 load; valid with mem_req_valid.
REQ-010 mem_req_wdata  output  2*REG_BITS  store data.
REQ-011 mem_req_ready  input  1  memory accepts request when high with mem_req_valid.
REQ-012 mem_rsp_valid  input  1  load data returned this cycle.
REQ-013 mem_rsp_data  input  2*REG_BITS  load data.
REQ-014 alu_advance  output  1  drives ALU advance and regfile_en.
REQ-015 alu_data_in  output  NSHIFT  serial operand to ALU data_in1/data_in2, LSB chunk first.
REQ-016 alu_data_out  input  NSHIFT  serial result from ALU data_out.
REQ-017 alu_op_done  input  1  ALU last-cycle indication.
REQ-018 busy  output  1  high in any state other than IDLE.
REQ-019 done  output  1  one-cycle pulse on transaction completion.
REQ-020 result  output  2*REG_BITS  captured result, stable from done until next start.
REQ-021 sync_error  output  1  sticky; set when alu_op_done disagrees with internal last shift cycle.

Function
REQ-022 States: IDLE, LOAD_REQ, LOAD_WAIT, SHIFT, STORE_REQ; start in IDLE goes to LOAD_REQ if need_load else SHIFT.
REQ-023 LOAD_REQ: mem_req_valid=1, mem_req_write=0; on ready go to LOAD_WAIT.
REQ-024 LOAD_WAIT: on mem_rsp_valid latch mem_rsp_data into operand shift register, go to SHIFT; mem_rsp_valid in other states ignored.
REQ-025 Without need_load, operand register is zero.
REQ-026 SHIFT: alu_advance=1 every cycle; length pair ? 2*REG_BITS/NSHIFT : REG_BITS/NSHIFT cycles (8 or 4 by default).
REQ-027 alu_data_in = operand[NSHIFT-1:0]; operand shifts right NSHIFT per SHIFT cycle, zero fill.
REQ-028 Capture: result bits [NSHIFT*k +: NSHIFT] <= alu_data_out on SHIFT cycle k (k from 0); unwritten high bits cleared at start.
REQ-029 Last SHIFT cycle: go to STORE_REQ if need_store, else IDLE with done=1 next cycle.
REQ-030 sync_error set if alu_op_done=1 on a non-last SHIFT cycle or 0 on the last; cleared only by reset.
REQ-031 STORE_REQ: mem_req_valid=1, mem_req_write=1, mem_req_wdata=result, all held stable until ready; on ready go to IDLE, done=1 next cycle.
REQ-032 Zero-wait handshakes: request accepted same cycle valid asserted if ready high; no combinational path from mem_req_ready to mem_req_valid.
REQ-033 start while busy is ignored; start in the done cycle is accepted (IDLE).
REQ-034 Outside SHIFT, alu_advance=0 and alu_data_in=0.

Reset
REQ-035 Reset forces IDLE from any state, including mid-SHIFT or pending request; mem_req_valid, mem_req_write, alu_advance, busy, done, sync_error=0; result, mem_req_wdata, alu_data_in, counter=0.
REQ-036 A memory request pending at reset is abandoned; no retry after reset release.

Structure
REQ-037 State encoding and transfer-length constants live in the shared common package alongside existing op definitions.
REQ-038 One sub-module alu_mem_port_shifter (operand shift register plus result capture, indexed by cycle counter); FSM and handshakes in top.

Verification
REQ-039 Load 8-bit: pair=0, need_load=1, rsp 0x00B4 -> alu_data_in 0,1,3,2 over 4 cycles; loopback data_out=data_in gives result 0x00B4, done once.
REQ-040 Pair store: pair=1, need_store=1, data_out chunks 3,0,2,1,0,0,1,2 -> mem_req_wdata 0x9063, held 3 cycles with ready=0, done after accept.
REQ-041 Back-to-back: start asserted in done cycle -> second transaction begins next cycle, no lost cycle.
REQ-042 Sync: alu_op_done pulsed on SHIFT cycle 2 of 4 -> sync_error=1, sticky until reset.
REQ-043 Reset in SHIFT cycle 3 of 8 with rsp data 0xFFFF -> immediately IDLE, all outputs 0; stray mem_rsp_valid afterwards ignored.
REQ-044 start while busy in LOAD_WAIT -> ignored, single done.
